// File: rtl/mac_result_drain.sv
// mac_result_drain
// Downstream stage of the MAC processing element. Every MAC result is
// captured into a per-accumulator shadow buffer indexed by its tag. A flush
// scans the buffer in tag order and streams only the updated (dirty) entries
// over a valid/ready port. Each word is requantized from ACC_W to W bits with
// an arithmetic right shift followed by signed saturation.
//
// Build option: define MAC_RESULT_DRAIN_RELU_EN to clamp negative shifted
// values to zero, flagged through out_sat. When it is not defined, only
// signed saturation is applied.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_data,
// out_tag and out_sat stay unchanged. out_valid never drops without a
// transfer, except on clear or reset.
module mac_result_drain #(
   parameter int W       = 8,
   parameter int ACC_W   = 16,
   parameter int NUM_ACC = 8,
   parameter int TAG_W   = $clog2(NUM_ACC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               acc_valid,
   input  logic [TAG_W-1:0]   acc_tag,
   input  logic [ACC_W-1:0]   acc_in,
   input  logic               flush,
   input  logic [3:0]         shift_amt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_sat,
   output logic               busy,
   output logic               done
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Saturation limits, expressed at accumulator width for direct comparison.
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (W - 1)));

   logic [0:0]              state;
   logic [TAG_W-1:0]        ptr;
   logic [3:0]              shift_r;
   logic signed [ACC_W-1:0] acc_buf [NUM_ACC];
   logic [NUM_ACC-1:0]      dirty;
   // Set when the entry under ptr is rewritten after its word was sampled.
   // The entry must then stay dirty after the handshake so the newer value
   // is not lost.
   logic                    hit_r;

   logic                    last_entry;
   logic                    ptr_hit;
   logic signed [ACC_W-1:0] q_shift;
   logic signed [W-1:0]     q_data;
   logic                    q_sat;

   assign last_entry = (ptr == TAG_W'(NUM_ACC - 1));
   assign ptr_hit    = acc_valid && (acc_tag == ptr);
   assign busy       = (state == ST_DRAIN);

   // Requantize the entry under the scan pointer (shift, then clamp/saturate).
   always_comb begin
      q_shift = acc_buf[ptr] >>> shift_r;
      q_data  = q_shift[W-1:0];
      q_sat   = 1'b0;
`ifdef MAC_RESULT_DRAIN_RELU_EN
      if (q_shift[ACC_W-1]) begin
         q_data = '0;
         q_sat  = 1'b1;
      end else if (q_shift > SAT_MAX) begin
         q_data = SAT_MAX[W-1:0];
         q_sat  = 1'b1;
      end
`else
      if (q_shift > SAT_MAX) begin
         q_data = SAT_MAX[W-1:0];
         q_sat  = 1'b1;
      end else if (q_shift < SAT_MIN) begin
         q_data = SAT_MIN[W-1:0];
         q_sat  = 1'b1;
      end
`endif
   end

   // Shadow buffer: the last capture to a tag wins; clear zeroes every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ACC; i++) acc_buf[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_ACC; i++) acc_buf[i] <= '0;
      end else if (acc_valid) begin
         acc_buf[acc_tag] <= acc_in;
      end
   end

   // Drain FSM, dirty tracking and the registered output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         shift_r   <= '0;
         dirty     <= '0;
         hit_r     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_sat   <= 1'b0;
         done      <= 1'b0;
      end else if (clear) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         dirty     <= '0;
         hit_r     <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (flush) begin
                  state   <= ST_DRAIN;
                  ptr     <= '0;
                  shift_r <= shift_amt;
               end
            end
            ST_DRAIN: begin
               if (!out_valid) begin
                  // Scan step: present a dirty entry, or move past a clean one.
                  if (dirty[ptr]) begin
                     out_valid <= 1'b1;
                     out_tag   <= ptr;
                     out_data  <= q_data;
                     out_sat   <= q_sat;
                     hit_r     <= ptr_hit;
                  end else if (last_entry) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     ptr <= ptr + TAG_W'(1);
                  end
               end else if (out_ready) begin
                  // Handshake: retire the entry unless it was rewritten meanwhile.
                  out_valid  <= 1'b0;
                  dirty[ptr] <= hit_r;
                  if (last_entry) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     ptr <= ptr + TAG_W'(1);
                  end
               end else if (ptr_hit) begin
                  hit_r <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         // A capture always marks its entry dirty, overriding a same-cycle retire.
         if (acc_valid) dirty[acc_tag] <= 1'b1;
      end
   end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream stage of the MAC processing element.
- Captures every `acc_out`/`valid_out` result into a per-accumulator shadow buffer, indexed by the tag the MAC selected (its `acc_sel`, registered alongside the result).
- On a flush request, scans the buffer in tag order and streams only updated entries over a valid/ready interface.
- Each streamed value is requantized from ACC_W to W bits with an arithmetic shift and signed saturation.

Parameters:
- W, 8, output data width (signed).
- ACC_W, 16, accumulator/input data width (signed).
- NUM_ACC, 8, number of buffer entries; must be a power of two, ≥2.
- TAG_W, $clog2(NUM_ACC), tag width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of buffer, dirty bits and drain state.
- acc_valid  input  1  capture strobe (from MAC `valid_out`).
- acc_tag  input  TAG_W  entry index for the capture.
- acc_in  input  ACC_W  signed accumulator value (from MAC `acc_out`).
- flush  input  1  single-cycle request to drain dirty entries.
- shift_amt  input  4  right-shift amount, sampled on accepted flush.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer ready.
- out_data  output  W  requantized signed result.
- out_tag  output  TAG_W  index of the entry presented.
- out_sat  output  1  1 = out_data was saturated (or clamped, see option).
- busy  output  1  high while in DRAIN.
- done  output  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset (rst_n low, async):
  - buf[*]=0, dirty[*]=0, state=IDLE, ptr=0, shift register=0.
  - out_valid=0, out_data=0, out_tag=0, out_sat=0, busy=0, done=0.
- Priority each cycle: clear > capture/drain logic.
- clear:
  - Zeroes buf and dirty; forces IDLE, out_valid=0, ptr=0.
  - No done pulse; a flush in the same cycle is dropped.
- Capture (any state, clear low): acc_valid=1 sets buf[acc_tag]<=acc_in and dirty[acc_tag]<=1. Last write wins; no accumulation here.
- States: IDLE, DRAIN.
- IDLE:
  - flush=1 → DRAIN next cycle; ptr<=0; shift_amt latched; busy=1 from the next cycle.
  - flush=1 with no dirty entries still enters DRAIN; it completes after the scan with a done pulse and no output words.
- DRAIN, out_valid=0 (scan step, one entry per cycle):
  - dirty[ptr]=1 → out_valid<=1, out_tag<=ptr, out_data/out_sat<=Q(buf[ptr]).
  - dirty[ptr]=0 and ptr=NUM_ACC-1 → done<=1, IDLE.
  - Otherwise ptr<=ptr+1.
- DRAIN, out_valid=1:
  - out_data, out_tag and out_sat are held stable until out_ready=1.
  - On handshake: out_valid<=0; dirty[ptr]<=0 unless a capture to ptr occurs the same cycle, in which case it stays 1.
  - After the handshake: ptr=NUM_ACC-1 → done<=1, IDLE; otherwise ptr<=ptr+1.
- Captures during DRAIN:
  - Tag > ptr: emitted in this drain with the new value.
  - Tag < ptr: stays dirty for the next flush.
  - Tag = ptr while presented: presented word unchanged, entry stays dirty.
- flush while in DRAIN: ignored.
- Latency:
  - flush at cycle t → first possible out_valid at t+2 (entry 0 dirty).
  - Each clean entry costs 1 cycle; each dirty entry costs ≥2 cycles.
  - With all entries dirty and out_ready tied high, done fires 2·NUM_ACC+1 cycles after flush.
- Requantization Q(x):
  - s = x >>> shift (arithmetic, sign-extended).
  - s > 2^(W-1)-1 → out_data=2^(W-1)-1, out_sat=1.
  - s < -2^(W-1) → out_data=-2^(W-1), out_sat=1.
  - Otherwise out_data=s[W-1:0], out_sat=0.
  - shift ≥ ACC_W yields 0 or -1 per sign.
- done is a single-cycle pulse, 0 otherwise.
- busy = (state==DRAIN).

Optional Feature:
- Macro: MAC_RESULT_DRAIN_RELU_EN.
- Defined:
  - After the shift, s<0 is clamped to 0 before saturation.
  - out_sat=1 for clamped values as well as saturated ones.
  - out_data is never negative.
- Undefined: signed saturation only, as specified above.

Test Plan:
- Reset mid-drain: rst_n low with out_valid=1 → all outputs 0 immediately. Then flush → done at t+NUM_ACC+1 (=t+9) with zero output words.
- Capture tags 2 and 5 with 300 and -40; flush with shift_amt=1, out_ready=1:
  - Words in order: (tag 2, 127, sat=1) then (tag 5, -20, sat=0).
  - done after ptr 7; dirty all 0.
- Backpressure: out_ready=0 for 5 cycles while tag 0 is presented → out_data/out_tag/out_sat stable. Accepted on the cycle out_ready rises.
- Capture during drain:
  - While tag 3 is presented, capture tag 3 = 50 → presented value unchanged, entry 3 dirty after done.
  - Capture tag 6 = 10 in the same drain → emitted as 10 in this drain.
- clear asserted together with flush and acc_valid → flush and capture both dropped; next flush outputs nothing.
- MAC_RESULT_DRAIN_RELU_EN: tag 1 = -1000, shift 2 → out_data=0, out_sat=1. Without the macro → -128, out_sat=1.
